// File: rtl/xnor_pattern_correlator.sv
// xnor_pattern_correlator: serial window XNOR-correlated against a pattern, thresholded detect, saturating detect count
module xnor_pattern_correlator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8,
   localparam int SW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic [WIDTH-1:0] pattern,
   input  logic [SW-1:0]    thresh,
   output logic [WIDTH-1:0] window,
   output logic             window_full,
   output logic [SW-1:0]    score,
   output logic             detect,
   output logic [CNT_W-1:0] det_count
);
   logic [SW-1:0] fill;
   logic [SW-1:0] pc;
   logic          shifted;
   logic          hit;
   logic [WIDTH-1:0] match;
   assign match = ~(window ^ pattern);
   assign window_full = fill == SW'(WIDTH);
   always_comb begin
      pc = '0;
      for (int i = 0; i < WIDTH; i++) pc = pc + SW'(match[i]);
   end
   // score/detect judge the window as it stands after the previous accepted bit
   assign hit = shifted & window_full & (pc >= thresh);
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clear) begin
         window    <= '0;
         fill      <= '0;
         shifted   <= 1'b0;
         score     <= '0;
         detect    <= 1'b0;
         det_count <= '0;
      end else begin
         if (in_valid) begin
            window <= {window[WIDTH-2:0], in_bit};
            fill   <= window_full ? fill : fill + SW'(1);
         end
         shifted <= in_valid;
         score   <= shifted ? pc : score;
         detect  <= hit;
         if (hit && !(&det_count)) det_count <= det_count + CNT_W'(1);
      end
   end
endmodule
